// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the register-file write-port arbiter and its requesters,
// the register file write port and the read bypass.
interface regfile_wb_arbiter_if #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                             hold;
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             rf_wen;
    logic [ADDR_WIDTH-1:0]            rf_waddr;
    logic [DATA_WIDTH-1:0]            rf_wdata;
    logic [ADDR_WIDTH-1:0]            byp_raddr;
    logic                             byp_hit;
    logic [DATA_WIDTH-1:0]            byp_data;

    // Arbiter side.
    modport slave (
        input  hold, req_valid, req_addr, req_data, byp_raddr,
        output req_ready, rf_wen, rf_waddr, rf_wdata, byp_hit, byp_data
    );

    // Requester / register-file side.
    modport master (
        output hold, req_valid, req_addr, req_data, byp_raddr,
        input  req_ready, rf_wen, rf_waddr, rf_wdata, byp_hit, byp_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between NUM_REQ writeback requesters.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave wb
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic                  grant_en_c;
    logic                  gnt_vld_c;
    logic                  gnt_fire_c;
    logic [IDX_W-1:0]      gnt_idx_c;
    logic [ADDR_WIDTH-1:0] gnt_addr_c;
    logic [DATA_WIDTH-1:0] gnt_data_c;
    logic [NUM_REQ-1:0]    req_ready_c;

    logic                  wen_q,   wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Reset is folded in so no requester sees ready while reset is asserted.
    assign grant_en_c = rst & ~wb.hold;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Search from ptr upward, wrapping; first valid requester wins.
    always_comb begin
        int unsigned idx;
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!gnt_vld_c && wb.req_valid[IDX_W'(idx)]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_fire_c) begin
            ptr_d = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest valid index wins.
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_vld_c && wb.req_valid[i]) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = IDX_W'(i);
            end
        end
    end
`endif

    assign gnt_fire_c = grant_en_c & gnt_vld_c;

    // One-hot ready and payload mux of the winning slice.
    always_comb begin
        req_ready_c = '0;
        gnt_addr_c  = '0;
        gnt_data_c  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx_c == IDX_W'(i)) begin
                req_ready_c[i] = gnt_fire_c;
                gnt_addr_c     = wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_data_c     = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Writes to x0 complete the handshake but never reach the register file.
    always_comb begin
        wen_d   = gnt_fire_c && (gnt_addr_c != '0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt_fire_c) begin
            waddr_d = gnt_addr_c;
            wdata_d = gnt_data_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wb.req_ready = req_ready_c;
    assign wb.rf_wen    = wen_q;
    assign wb.rf_waddr  = waddr_q;
    assign wb.rf_wdata  = wdata_q;
    assign wb.byp_hit   = wen_q && (waddr_q == wb.byp_raddr);
    assign wb.byp_data  = wdata_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(wb.req_ready));
    a_ready_valid: assert property (@(posedge clk) disable iff (!rst)
        (wb.req_ready & ~wb.req_valid) == '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a reference model
// of the grant rules and the one-cycle write stage.
module tb_regfile_wb_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Requester-side pending writes.
    logic          pv [N];
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];

    // Model of what the register file should see next cycle.
    int            m_ptr;
    logic          m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    logic [N-1:0]  last_ready;
    logic          last_hit;
    logic          last_wen;
    logic [AW-1:0] last_waddr;
    logic [DW-1:0] last_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (!rst || bus.hold) return -1;
`ifdef WB_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < int'(N); k++) begin
            if (pv[(m_ptr + k) % int'(N)]) return (m_ptr + k) % int'(N);
        end
`else
        for (int i = 0; i < int'(N); i++) begin
            if (pv[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_ptr   = 0;
    endtask

    function automatic logic any_pending();
        for (int i = 0; i < int'(N); i++) if (pv[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a falling edge: drive, check, advance the model, go to next falling edge.
    task automatic step();
        int           g;
        logic [N-1:0] exp_rdy;
        logic         exp_hit;
        for (int i = 0; i < int'(N); i++) begin
            bus.req_valid[i]          = pv[i];
            bus.req_addr[i*AW +: AW]  = pa[i];
            bus.req_data[i*DW +: DW]  = pd[i];
        end
        #1;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_hit = m_wen && (m_waddr == bus.byp_raddr);
        last_ready = bus.req_ready;
        last_hit   = bus.byp_hit;
        last_wen   = bus.rf_wen;
        last_waddr = bus.rf_waddr;
        last_wdata = bus.rf_wdata;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("rf_wen",    64'(bus.rf_wen),    64'(m_wen));
        check("rf_waddr",  64'(bus.rf_waddr),  64'(m_waddr));
        check("rf_wdata",  64'(bus.rf_wdata),  64'(m_wdata));
        check("byp_hit",   64'(bus.byp_hit),   64'(exp_hit));
        if (exp_hit) check("byp_data", 64'(bus.byp_data), 64'(m_wdata));
        if (!rst) begin
            model_reset();
        end else if (g >= 0) begin
            m_wen   = (pa[g] != '0);
            m_waddr = pa[g];
            m_wdata = pd[g];
            m_ptr   = (g + 1) % int'(N);
            pv[g]   = 1'b0;
        end else begin
            m_wen = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && any_pending(); k++) step();
        check("drain_timeout", 64'(any_pending()), 64'(0));
    endtask

    task automatic arm(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pv[i] = 1'b1;
        pa[i] = a;
        pd[i] = d;
    endtask

    initial begin
        logic [N-1:0] exp_rr;
        rst           = 1'b0;
        bus.hold      = 1'b0;
        bus.byp_raddr = '0;
        model_reset();
        for (int i = 0; i < int'(N); i++) arm(i, AW'(i + 3), $urandom);
        @(negedge clk);

        // Reset held with every requester valid.
        repeat (2) begin
            step();
            check("rst_ready", 64'(last_ready), 64'(0));
            check("rst_wen",   64'(last_wen),   64'(0));
        end
        rst = 1'b1;

        // Contention for 6 cycles, re-arming whoever was just granted.
        for (int c = 0; c < 6; c++) begin
            step();
`ifdef WB_ARB_ROUND_ROBIN_EN
            exp_rr = N'(1) << (c % int'(N));
`else
            exp_rr = N'(1);
`endif
            check("contend_order", 64'(last_ready), 64'(exp_rr));
            for (int i = 0; i < int'(N); i++) if (!pv[i]) arm(i, AW'(i + 10), $urandom);
        end
        drain();

        // Single write with bypass in the following cycle.
        arm(1, AW'(5), 32'h1234_5678);
        step();
        check("single_ready", 64'(last_ready), 64'(3'b010));
        bus.byp_raddr = AW'(5);
        step();
        check("single_wen",   64'(last_wen),   64'(1));
        check("single_waddr", 64'(last_waddr), 64'(5));
        check("single_wdata", 64'(last_wdata), 64'(32'h1234_5678));
        check("single_byp",   64'(last_hit),   64'(1));

        // Write to x0 is acknowledged but dropped.
        arm(2, '0, 32'hDEAD_BEEF);
        bus.byp_raddr = '0;
        step();
        check("x0_ready", 64'(last_ready), 64'(3'b100));
        step();
        check("x0_wen", 64'(last_wen), 64'(0));
        for (int i = 0; i < int'(N); i++) arm(i, AW'(i + 20), $urandom);
        step();
        check("x0_next_gnt", 64'(last_ready), 64'(3'b001));
        drain();

        // Hold freezes grants while requester 1 waits.
        step();
        arm(1, AW'(9), $urandom);
        bus.hold = 1'b1;
        repeat (3) begin
            step();
            check("hold_ready", 64'(last_ready), 64'(0));
            check("hold_wen",   64'(last_wen),   64'(0));
        end
        bus.hold = 1'b0;
        step();
        check("hold_release", 64'(last_ready), 64'(3'b010));

        // Asynchronous reset with a write in the output stage.
        arm(0, AW'(7), $urandom);
        step();
        #1;
        check("mid_wen_before", 64'(bus.rf_wen), 64'(1));
        rst = 1'b0;
        #1;
        check("mid_wen",   64'(bus.rf_wen),   64'(0));
        check("mid_waddr", 64'(bus.rf_waddr), 64'(0));
        model_reset();
        @(negedge clk);
        arm(2, AW'(12), $urandom);
        step();
        check("mid_no_gnt", 64'(last_ready), 64'(0));
        rst = 1'b1;
        drain();

        // Randomized traffic, hold and bypass addresses.
        repeat (400) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 50)
                    arm(i, ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom), $urandom);
            end
            bus.hold      = ($urandom_range(0, 9) == 0);
            bus.byp_raddr = $urandom_range(0, 1) ? m_waddr : AW'($urandom);
            step();
        end
        bus.hold = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
